// File: rtl/branch_pred_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_pred_ctrl_pkg                                                 |
// | Shared counter encodings, FSM states and counter update helper.      |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
package branch_pred_ctrl_pkg;

    localparam logic [1:0] CTR_ST = 2'b00;
    localparam logic [1:0] CTR_WT = 2'b01;
    localparam logic [1:0] CTR_WN = 2'b10;
    localparam logic [1:0] CTR_SN = 2'b11;

    localparam logic [1:0] INIT    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    // Taken moves toward strong-taken (00), not-taken toward strong-not (11).
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        case (ctr)
            CTR_ST:  return taken ? CTR_ST : CTR_WT;
            CTR_WT:  return taken ? CTR_ST : CTR_WN;
            CTR_WN:  return taken ? CTR_WT : CTR_SN;
            default: return taken ? CTR_WN : CTR_SN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_table                                                             |
// | Direct-mapped branch table: async read, sync write/update, clear.    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module bp_table #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [31:0]      rd_tag,
    output logic [31:0]      rd_target,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_tag,
    input  logic [31:0]      wr_target,
    input  logic             wr_taken
);
    import branch_pred_ctrl_pkg::*;

    logic        r_valid  [ENTRIES];
    logic [31:0] r_tag    [ENTRIES];
    logic [31:0] r_target [ENTRIES];
    logic [1:0]  r_ctr    [ENTRIES];

    logic w_wr_hit;

    assign rd_valid  = r_valid[rd_idx];
    assign rd_tag    = r_tag[rd_idx];
    assign rd_target = r_target[rd_idx];
    assign rd_ctr    = r_ctr[rd_idx];

    assign w_wr_hit  = r_valid[wr_idx] & (r_tag[wr_idx] == wr_tag);

    // A tag mismatch reallocates the slot, evicting any aliased branch.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            r_valid[clr_idx] <= 1'b0;
            r_ctr[clr_idx]   <= CTR_SN;
        end else if (wr_en) begin
            if (w_wr_hit) begin
                r_ctr[wr_idx] <= ctr_update(r_ctr[wr_idx], wr_taken);
                if (wr_taken) begin
                    r_target[wr_idx] <= wr_target;
                end
            end else begin
                r_valid[wr_idx]  <= 1'b1;
                r_tag[wr_idx]    <= wr_tag;
                r_target[wr_idx] <= wr_target;
                r_ctr[wr_idx]    <= wr_taken ? CTR_WT : CTR_SN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_pred_ctrl                                                     |
// | Branch predictor FSM: lookup, resolution, flush/redirect, stats.     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module branch_pred_ctrl #(
    parameter int ENTRIES = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_branch,
    input  logic [31:0]      id_pc_plus4,
    input  logic             mem_branch,
    input  logic [31:0]      mem_pc_plus4,
    input  logic             mem_taken,
    input  logic [31:0]      mem_target,
    input  logic             mem_pred_taken,
    input  logic [31:0]      mem_pred_pc,
    output logic             busy,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    import branch_pred_ctrl_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ENTRIES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic             w_init;
    logic             w_run;
    logic             w_hit;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_rd_valid;
    logic [31:0]      w_rd_tag;
    logic [31:0]      w_rd_target;
    logic [1:0]       w_rd_ctr;

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk       (clk),
        .clr_en    (w_init),
        .clr_idx   (r_clr_idx),
        .rd_idx    (id_pc_plus4[IDX_W+1:2]),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_target (w_rd_target),
        .rd_ctr    (w_rd_ctr),
        .wr_en     (w_resolve),
        .wr_idx    (mem_pc_plus4[IDX_W+1:2]),
        .wr_tag    (mem_pc_plus4),
        .wr_target (mem_target),
        .wr_taken  (mem_taken)
    );

    assign w_init    = (r_state == INIT);
    assign w_run     = (r_state == RUN);
    // Table contents are meaningless until the clear sequence completes.
    assign w_hit     = ~w_init & w_rd_valid & (w_rd_tag == id_pc_plus4);
    assign w_resolve = w_run & mem_branch;

    assign w_mispredict = w_resolve &
                          ((mem_taken != mem_pred_taken) |
                           (mem_taken & mem_pred_taken & (mem_target != mem_pred_pc)));

    assign busy        = w_init;
    assign pred_taken  = w_run & id_branch & w_hit & ~w_rd_ctr[1];
    assign pred_pc     = w_hit ? w_rd_target : id_pc_plus4;
    assign flush       = w_mispredict;
    assign redirect_pc = w_mispredict ? (mem_taken ? mem_target : mem_pc_plus4) : 32'd0;
    assign br_cnt      = r_br_cnt;
    assign miss_cnt    = r_miss_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (r_clr_idx == c_last_idx) w_state_nxt = RUN;
            RUN:     if (w_mispredict) w_state_nxt = RECOVER;
            RECOVER: w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_clr_idx  <= '0;
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init) begin
                r_clr_idx <= r_clr_idx + IDX_W'(1);
            end
            if (w_resolve && (r_br_cnt != {CNT_W{1'b1}})) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
